be_clock_gen: RTL and testbench

//  Parametrised clock/control generator for the 8-bit computer. Divides iCLK to a selectable CPU clock.

---
 rtl/be_clock_pkg.sv | 25 ++
 rtl/be_debounce.sv | 43 ++++
 rtl/be_clock_gen.sv | 191 +++++++++++++++++++
 tb/tb_be_clock_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/be_clock_pkg.sv
// Shared types and helpers for the front-panel clock generator of the 8-bit computer.
// Holds the FSM state encoding, MODE codes and the half-period calculation.
package be_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  // iCLK cycles per CPU clock phase; the all-ones select is the fastest setting (iCLK/2).
  function automatic int unsigned half_period(input int unsigned sys_hz, input int unsigned base_hz,
                                              input int unsigned sel, input int unsigned sel_w);
    int unsigned h;
    h = (sys_hz / (2 * base_hz)) >> sel;
    if (sel == ((32'd1 << sel_w) - 32'd1) || h == 0) h = 1;
    return h;
  endfunction

endpackage

// File: rtl/be_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and one-cycle pulse per accepted press.
// Reusable for any front-panel button.
module be_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pls
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pls   <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      pls  <= 1'b0;
      // The new level must hold for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync;
        pls   <= sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/be_clock_gen.sv
// CPU clock generator: run / single-step / burst modes, cycle-clean halt, and a free-running display tick.
// All outputs are registered; CLK_RISE/CLK_FALL let downstream logic stay on iCLK with enables.
module be_clock_gen
  import be_clock_pkg::*;
#(
  parameter int SYS_CLK_HZ      = 50_000_000,
  parameter int BASE_HZ         = 1,
  parameter int SEL_W           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BURST_W         = 8,
  parameter int DISP_CYCLES     = 125_000_000,
  parameter int CNT_W           = 16
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [1:0]         MODE,
  input  logic [SEL_W-1:0]   DIV_SEL,
  input  logic               STEP,
  input  logic [BURST_W-1:0] BURST_LEN,
  input  logic               HLT,
  input  logic               CLR,
  output logic               CLK,
  output logic               NOT_CLK,
  output logic               CLK_RISE,
  output logic               CLK_FALL,
  output logic               HALTED,
  output logic               BUSY,
  output logic [CNT_W-1:0]   CYCLE_CNT,
  output logic               DISPLAY_TICK
);

  localparam int HALF_MAX = SYS_CLK_HZ / (2 * BASE_HZ);
  localparam int HW       = (HALF_MAX > 1) ? $clog2(HALF_MAX + 1) : 1;
  localparam int DW       = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam int SW       = 2 + SEL_W + 2;
  // Synchronised MODE resets to step so the FSM cannot start a run cycle before real MODE arrives.
  localparam logic [SW-1:0] SYNC_RST = {MODE_STEP, {SEL_W{1'b0}}, 2'b00};

  logic [SW-1:0]      sync_meta;
  logic [SW-1:0]      sync_q;
  logic [1:0]         mode_s;
  logic [SEL_W-1:0]   sel_s;
  logic               hlt_s;
  logic               clr_s;
  logic               step_pls;
  logic [HW-1:0]      half_next;
  logic [BURST_W-1:0] burst_load;
  logic               run_mode;
  logic               phase_end;

  state_t             state;
  logic [HW-1:0]      phase_cnt;
  logic [HW-1:0]      half_reg;
  logic [BURST_W-1:0] remaining;
  logic [DW-1:0]      disp_cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_meta <= SYNC_RST;
      sync_q    <= SYNC_RST;
    end else begin
      sync_meta <= {MODE, DIV_SEL, HLT, CLR};
      sync_q    <= sync_meta;
    end
  end

  assign {mode_s, sel_s, hlt_s, clr_s} = sync_q;

  be_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk  (iCLK),
    .rst_n(iRST_N),
    .btn  (STEP),
    .pls  (step_pls)
  );

  assign half_next  = HW'(half_period(SYS_CLK_HZ, BASE_HZ, 32'(sel_s), SEL_W));
  assign burst_load = (BURST_LEN == '0) ? BURST_W'(1) : BURST_LEN;
  assign run_mode   = (mode_s == MODE_RUN);
  assign phase_end  = (phase_cnt == half_reg - HW'(1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      CLK       <= 1'b0;
      NOT_CLK   <= 1'b1;
      CLK_RISE  <= 1'b0;
      CLK_FALL  <= 1'b0;
      HALTED    <= 1'b0;
      BUSY      <= 1'b0;
      CYCLE_CNT <= '0;
      phase_cnt <= '0;
      half_reg  <= '0;
      remaining <= '0;
    end else begin
      CLK_RISE <= 1'b0;
      CLK_FALL <= 1'b0;
      if (clr_s) begin
        state     <= ST_IDLE;
        CLK       <= 1'b0;
        NOT_CLK   <= 1'b1;
        CLK_FALL  <= CLK;
        HALTED    <= 1'b0;
        BUSY      <= 1'b0;
        CYCLE_CNT <= '0;
        phase_cnt <= '0;
        remaining <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (hlt_s) begin
              state  <= ST_HALT;
              HALTED <= 1'b1;
            end else if (run_mode || step_pls) begin
              state     <= ST_HIGH;
              CLK       <= 1'b1;
              NOT_CLK   <= 1'b0;
              CLK_RISE  <= 1'b1;
              BUSY      <= 1'b1;
              CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
              phase_cnt <= '0;
              half_reg  <= half_next;
              remaining <= (mode_s == MODE_BURST) ? burst_load : BURST_W'(1);
            end
          end
          ST_HIGH: begin
            if (phase_end) begin
              CLK       <= 1'b0;
              NOT_CLK   <= 1'b1;
              CLK_FALL  <= 1'b1;
              phase_cnt <= '0;
              half_reg  <= half_next;
              if (hlt_s) begin
                state  <= ST_HALT;
                HALTED <= 1'b1;
                BUSY   <= 1'b0;
              end else begin
                state <= ST_LOW;
              end
            end else begin
              phase_cnt <= phase_cnt + HW'(1);
            end
          end
          ST_LOW: begin
            if (phase_end) begin
              if (hlt_s) begin
                state  <= ST_HALT;
                HALTED <= 1'b1;
                BUSY   <= 1'b0;
              end else if (run_mode || remaining > BURST_W'(1)) begin
                state     <= ST_HIGH;
                CLK       <= 1'b1;
                NOT_CLK   <= 1'b0;
                CLK_RISE  <= 1'b1;
                CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
                phase_cnt <= '0;
                half_reg  <= half_next;
                if (!run_mode) remaining <= remaining - BURST_W'(1);
              end else begin
                state     <= ST_IDLE;
                BUSY      <= 1'b0;
                remaining <= '0;
              end
            end else begin
              phase_cnt <= phase_cnt + HW'(1);
            end
          end
          ST_HALT: begin
            state <= ST_HALT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      disp_cnt     <= '0;
      DISPLAY_TICK <= 1'b0;
    end else if (disp_cnt == DW'(DISP_CYCLES - 1)) begin
      disp_cnt     <= '0;
      DISPLAY_TICK <= 1'b1;
    end else begin
      disp_cnt     <= disp_cnt + DW'(1);
      DISPLAY_TICK <= 1'b0;
    end
  end

endmodule

// File: tb/tb_be_clock_gen.sv
// Directed bench for be_clock_gen with small parameters (HALF=32 at DIV_SEL=0, 4-cycle debounce, tick every 10).
module tb_be_clock_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] MODE;
  logic [2:0] DIV_SEL;
  logic       STEP;
  logic [7:0] BURST_LEN;
  logic       HLT;
  logic       CLR;
  logic       CLK, NOT_CLK, CLK_RISE, CLK_FALL, HALTED, BUSY, DISPLAY_TICK;
  logic [15:0] CYCLE_CNT;

  int vectors = 0;
  int miscompares = 0;

  be_clock_gen #(
    .SYS_CLK_HZ(64), .BASE_HZ(1), .SEL_W(3), .DEBOUNCE_CYCLES(4),
    .BURST_W(8), .DISP_CYCLES(10), .CNT_W(16)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .MODE(MODE), .DIV_SEL(DIV_SEL), .STEP(STEP),
    .BURST_LEN(BURST_LEN), .HLT(HLT), .CLR(CLR), .CLK(CLK), .NOT_CLK(NOT_CLK),
    .CLK_RISE(CLK_RISE), .CLK_FALL(CLK_FALL), .HALTED(HALTED), .BUSY(BUSY),
    .CYCLE_CNT(CYCLE_CNT), .DISPLAY_TICK(DISPLAY_TICK)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int limit, output bit ok);
    int n = 0;
    while (CLK_RISE !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (CLK_RISE === 1'b1);
  endtask

  // Length in samples of the phase that holds the current CLK value; optionally retargets DIV_SEL mid-phase.
  task automatic measure_phase(input int change_at, input logic [2:0] new_sel, output int n);
    logic v;
    v = CLK;
    n = 0;
    while (CLK === v && n < 300) begin
      if (n == change_at) DIV_SEL = new_sel;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; MODE = 2'b00; DIV_SEL = 3'd0; STEP = 1'b0; BURST_LEN = 8'd0; HLT = 1'b0; CLR = 1'b0;
    cyc(3);
    vectors++; if (CLK !== 1'b0) begin miscompares++; $display("FAIL reset_clk: got %b want 0", CLK); end
    vectors++; if (NOT_CLK !== 1'b1) begin miscompares++; $display("FAIL reset_not_clk: got %b want 1", NOT_CLK); end
    vectors++; if (CLK_RISE !== 1'b0 || CLK_FALL !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got %b%b want 00", CLK_RISE, CLK_FALL); end
    vectors++; if (HALTED !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", HALTED); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    vectors++; if (CYCLE_CNT !== 16'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", CYCLE_CNT); end
    vectors++; if (DISPLAY_TICK !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", DISPLAY_TICK); end
    $display("reset: outputs checked");
  endtask

  task automatic test_run;
    bit ok;
    int highs, rises, bad;
    logic fall32, rise64;
    rst_n = 1'b1;
    wait_rise(100, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL run_first_rise: got none want rise within 100"); end
    vectors++; if (CYCLE_CNT !== 16'd1) begin miscompares++; $display("FAIL run_cnt1: got %0d want 1", CYCLE_CNT); end
    highs = 1; rises = 0; bad = 0; fall32 = 1'b0; rise64 = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i < 64) begin
        if (CLK === 1'b1) highs++;
        if (CLK_RISE === 1'b1) rises++;
      end
      if (NOT_CLK !== ~CLK) bad++;
      if (i == 32) fall32 = CLK_FALL;
      if (i == 64) rise64 = CLK_RISE;
    end
    vectors++; if (highs != 32) begin miscompares++; $display("FAIL run_high_len: got %0d want 32", highs); end
    vectors++; if (rises != 0 || rise64 !== 1'b1) begin miscompares++; $display("FAIL run_period: got %0d extra rises, rise@64=%b want 0,1", rises, rise64); end
    vectors++; if (fall32 !== 1'b1) begin miscompares++; $display("FAIL run_fall32: got %b want 1", fall32); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL run_not_clk: got %0d bad samples want 0", bad); end
    vectors++; if (CYCLE_CNT !== 16'd2) begin miscompares++; $display("FAIL run_cnt2: got %0d want 2", CYCLE_CNT); end
    $display("run div0: high=%0d cnt=%0d", highs, CYCLE_CNT);
  endtask

  task automatic test_div_change;
    bit ok;
    int n_hi, n_lo, n_hi2, toggles, rises;
    logic prev;
    wait_rise(100, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL div_rise: got none want rise"); end
    measure_phase(5, 3'd2, n_hi);
    measure_phase(-1, 3'd2, n_lo);
    measure_phase(-1, 3'd2, n_hi2);
    vectors++; if (n_hi != 32) begin miscompares++; $display("FAIL div_cur_phase: got %0d want 32", n_hi); end
    vectors++; if (n_lo != 8) begin miscompares++; $display("FAIL div_low8: got %0d want 8", n_lo); end
    vectors++; if (n_hi2 != 8) begin miscompares++; $display("FAIL div_high8: got %0d want 8", n_hi2); end
    DIV_SEL = 3'd7;
    cyc(20);
    toggles = 0; rises = 0; prev = CLK;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (CLK !== prev) toggles++;
      if (CLK_RISE === 1'b1) rises++;
      prev = CLK;
    end
    vectors++; if (toggles != 10 || rises != 5) begin miscompares++; $display("FAIL div7_period2: got %0d toggles %0d rises want 10,5", toggles, rises); end
    MODE = 2'b01; DIV_SEL = 3'd0;
    cyc(80);
    vectors++; if (BUSY !== 1'b0 || CLK !== 1'b0) begin miscompares++; $display("FAIL leave_run: got busy=%b clk=%b want 0,0", BUSY, CLK); end
    $display("div change: %0d/%0d/%0d, sel7 toggles=%0d", n_hi, n_lo, n_hi2, toggles);
  endtask

  task automatic test_step;
    int rises, highs;
    logic busy_mid;
    CLR = 1'b1; cyc(3); CLR = 1'b0; cyc(4);
    vectors++; if (CYCLE_CNT !== 16'd0) begin miscompares++; $display("FAIL step_clr_cnt: got %0d want 0", CYCLE_CNT); end
    rises = 0;
    STEP = 1'b1; cyc(2); STEP = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (CLK_RISE === 1'b1) rises++;
    end
    vectors++; if (rises != 0) begin miscompares++; $display("FAIL step_glitch: got %0d rises want 0", rises); end
    rises = 0; highs = 0; busy_mid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 0) STEP = 1'b1;
      if (i == 10) STEP = 1'b0;
      if (i == 30) STEP = 1'b1;
      if (i == 42) STEP = 1'b0;
      @(negedge clk);
      if (CLK_RISE === 1'b1) rises++;
      if (CLK === 1'b1) highs++;
      if (i == 50) busy_mid = BUSY;
    end
    vectors++; if (rises != 1) begin miscompares++; $display("FAIL step_rises: got %0d want 1", rises); end
    vectors++; if (highs != 32) begin miscompares++; $display("FAIL step_high_len: got %0d want 32", highs); end
    vectors++; if (busy_mid !== 1'b1) begin miscompares++; $display("FAIL step_busy_mid: got %b want 1", busy_mid); end
    vectors++; if (CYCLE_CNT !== 16'd1) begin miscompares++; $display("FAIL step_cnt: got %0d want 1", CYCLE_CNT); end
    vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL step_idle: got busy=%b want 0", BUSY); end
    $display("step: rises=%0d high=%0d cnt=%0d", rises, highs, CYCLE_CNT);
  endtask

  task automatic test_burst;
    int rises, highs;
    MODE = 2'b10; BURST_LEN = 8'd3;
    cyc(4);
    rises = 0; highs = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 0) STEP = 1'b1;
      if (i == 10) STEP = 1'b0;
      @(negedge clk);
      if (CLK_RISE === 1'b1) rises++;
      if (CLK === 1'b1) highs++;
    end
    vectors++; if (rises != 3) begin miscompares++; $display("FAIL burst3_rises: got %0d want 3", rises); end
    vectors++; if (highs != 96) begin miscompares++; $display("FAIL burst3_high: got %0d want 96", highs); end
    vectors++; if (BUSY !== 1'b0 || CLK !== 1'b0) begin miscompares++; $display("FAIL burst3_idle: got busy=%b clk=%b want 0,0", BUSY, CLK); end
    $display("burst len3: rises=%0d", rises);
    BURST_LEN = 8'd0;
    cyc(2);
    rises = 0;
    for (int i = 0; i < 150; i++) begin
      if (i == 0) STEP = 1'b1;
      if (i == 10) STEP = 1'b0;
      @(negedge clk);
      if (CLK_RISE === 1'b1) rises++;
    end
    vectors++; if (rises != 1) begin miscompares++; $display("FAIL burst0_rises: got %0d want 1", rises); end
    $display("burst len0: rises=%0d", rises);
  endtask

  task automatic test_halt;
    bit ok;
    int n, rises, ticks;
    MODE = 2'b00; DIV_SEL = 3'd0;
    cyc(3);
    wait_rise(200, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL halt_rise: got none want rise"); end
    n = 0;
    while (CLK === 1'b1 && n < 300) begin
      if (n == 10) HLT = 1'b1;
      n++;
      @(negedge clk);
    end
    vectors++; if (n != 32) begin miscompares++; $display("FAIL halt_high_done: got %0d want 32", n); end
    cyc(3);
    vectors++; if (HALTED !== 1'b1 || CLK !== 1'b0 || BUSY !== 1'b0) begin miscompares++; $display("FAIL halt_state: got halted=%b clk=%b busy=%b want 1,0,0", HALTED, CLK, BUSY); end
    MODE = 2'b01;
    cyc(3);
    rises = 0; ticks = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 0) STEP = 1'b1;
      if (i == 10) STEP = 1'b0;
      @(negedge clk);
      if (CLK_RISE === 1'b1) rises++;
      if (DISPLAY_TICK === 1'b1) ticks++;
    end
    vectors++; if (rises != 0 || HALTED !== 1'b1) begin miscompares++; $display("FAIL halt_step_ignored: got rises=%0d halted=%b want 0,1", rises, HALTED); end
    vectors++; if (ticks != 10) begin miscompares++; $display("FAIL halt_ticks: got %0d want 10", ticks); end
    n = 0;
    while (DISPLAY_TICK !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (DISPLAY_TICK !== 1'b1 && n < 30);
    vectors++; if (n != 10) begin miscompares++; $display("FAIL tick_period: got %0d want 10", n); end
    HLT = 1'b0; CLR = 1'b1; cyc(3); CLR = 1'b0; cyc(4);
    vectors++; if (HALTED !== 1'b0 || BUSY !== 1'b0 || CLK !== 1'b0) begin miscompares++; $display("FAIL clr_state: got halted=%b busy=%b clk=%b want 0,0,0", HALTED, BUSY, CLK); end
    vectors++; if (CYCLE_CNT !== 16'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d want 0", CYCLE_CNT); end
    $display("halt: high=32 held, ticks=%0d, cleared", ticks);
  endtask

  task automatic test_reset_mid_burst;
    bit ok;
    int rises;
    MODE = 2'b10; BURST_LEN = 8'd3;
    cyc(4);
    STEP = 1'b1;
    wait_rise(50, ok);
    STEP = 1'b0;
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rstb_rise: got none want rise"); end
    cyc(40);
    vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL rstb_busy: got %b want 1", BUSY); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (CLK !== 1'b0 || NOT_CLK !== 1'b1 || CLK_RISE !== 1'b0 || CLK_FALL !== 1'b0) begin miscompares++; $display("FAIL rstb_clk: got clk=%b nclk=%b r=%b f=%b want 0,1,0,0", CLK, NOT_CLK, CLK_RISE, CLK_FALL); end
    vectors++; if (BUSY !== 1'b0 || HALTED !== 1'b0 || CYCLE_CNT !== 16'd0 || DISPLAY_TICK !== 1'b0) begin miscompares++; $display("FAIL rstb_state: got busy=%b halted=%b cnt=%0d tick=%b want 0,0,0,0", BUSY, HALTED, CYCLE_CNT, DISPLAY_TICK); end
    @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (CLK_RISE === 1'b1) rises++;
    end
    vectors++; if (rises != 0) begin miscompares++; $display("FAIL rstb_no_resume: got %0d rises want 0", rises); end
    $display("reset mid-burst: async clear checked");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_run();
    test_div_change();
    test_step();
    test_burst();
    test_halt();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
